// File: rtl/cluster_pkg.sv
// rtl/cluster_pkg.sv - shared parameters, types and helpers for cluster address encoding
package cluster_pkg;

    localparam int MXSBITS    = 768;
    localparam int SEGSIZE    = 64;
    localparam int MXSEGS     = MXSBITS / SEGSIZE;
    localparam int OFFB       = 6;
    localparam int ADRB       = 10;
    localparam int MXCLUSTERS = 8;
    localparam int CNTB       = 4;
    localparam int IDXB       = 3;
    // Width of the published address field handed to the cluster packer
    localparam int CLSTB      = MXCLUSTERS * ADRB;

    typedef logic [ADRB-1:0] adr_t;
    typedef logic [CNTB-1:0] cnt_t;

    typedef struct packed {
        logic            any;
        logic [OFFB-1:0] off;
    } seg_hit_t;

    // Low n bits set; n may equal MXCLUSTERS for a full buffer
    function automatic logic [MXCLUSTERS-1:0] thermometer(input cnt_t n);
        logic [MXCLUSTERS-1:0] t;
        t = '0;
        for (int i = 0; i < MXCLUSTERS; i++) begin
            if (i < int'(n)) t[i] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/seg_lsb_encoder.sv
// rtl/seg_lsb_encoder.sv - registered lowest-set-bit encoder for one 64-bit segment
module seg_lsb_encoder
    import cluster_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [SEGSIZE-1:0] seg_bits,
    output seg_hit_t           hit
);

    logic [OFFB-1:0] off_c;

    // Scan high-to-low so the final write is the lowest set bit; empty segment gives 0
    always_comb begin
        off_c = '0;
        for (int i = SEGSIZE - 1; i >= 0; i--) begin
            if (seg_bits[i]) off_c = OFFB'(i);
        end
    end

    // Register the segment result (stage 1)
    always_ff @(posedge clock) begin
        if (reset) begin
            hit <= '0;
        end else begin
            hit.any <= |seg_bits;
            hit.off <= off_c;
        end
    end

endmodule

// File: rtl/cluster_address_encoder.sv
// rtl/cluster_address_encoder.sv - pipelined cluster address encode and per-frame collector
module cluster_address_encoder
    import cluster_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [MXSBITS-1:0]    vpfs_in,
    output logic [ADRB-1:0]       adr_out,
    output logic                  adr_vld,
    output logic [CLSTB-1:0]      clusters_out,
    output logic [MXCLUSTERS-1:0] cluster_vld,
    output logic [CNTB-1:0]       cluster_cnt,
    output logic                  overflow,
    output logic                  frame_done
);

    seg_hit_t        hit1 [MXSEGS];
    logic            tag1;
    logic            tag2;
    logic [ADRB-1:0] adr_c;
    logic            any_c;
    adr_t            cl_buf [MXCLUSTERS];
    cnt_t            cnt;
    logic            ovf_sticky;
    logic            primed;

    for (genvar s = 0; s < MXSEGS; s++) begin : g_seg
        seg_lsb_encoder u_enc (
            .clock    (clock),
            .reset    (reset),
            .seg_bits (vpfs_in[s*SEGSIZE +: SEGSIZE]),
            .hit      (hit1[s])
        );
    end

    // Frame tag travels alongside stage 1
    always_ff @(posedge clock) begin
        if (reset) tag1 <= 1'b0;
        else       tag1 <= frame_start;
    end

    // Pick the lowest non-empty segment; segment base is 64-aligned so OR forms the address
    always_comb begin
        adr_c = '0;
        any_c = 1'b0;
        for (int s = MXSEGS - 1; s >= 0; s--) begin
            if (hit1[s].any) adr_c = ADRB'(s * SEGSIZE) | ADRB'(hit1[s].off);
            any_c = any_c | hit1[s].any;
        end
    end

    // Stage 2 register: streaming address, valid and tag
    always_ff @(posedge clock) begin
        if (reset) begin
            adr_out <= '0;
            adr_vld <= 1'b0;
            tag2    <= 1'b0;
        end else begin
            adr_out <= adr_c;
            adr_vld <= any_c;
            tag2    <= tag1;
        end
    end

    // Collect the first MXCLUSTERS addresses of each frame; frame boundary restarts the buffer
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < MXCLUSTERS; k++) cl_buf[k] <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            primed     <= 1'b0;
        end else if (tag2) begin
            primed     <= 1'b1;
            ovf_sticky <= 1'b0;
            if (adr_vld) begin
                cl_buf[0] <= adr_out;
                cnt       <= CNTB'(1);
            end else begin
                cnt <= '0;
            end
        end else if (adr_vld) begin
            if (cnt < CNTB'(MXCLUSTERS)) begin
                cl_buf[cnt[IDXB-1:0]] <= adr_out;
                cnt                   <= cnt + CNTB'(1);
            end else begin
                ovf_sticky <= 1'b1;
            end
        end
    end

    // Publish the finished frame on the boundary; the partial frame before priming is dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            clusters_out <= '0;
            cluster_vld  <= '0;
            cluster_cnt  <= '0;
            overflow     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tag2 && primed) begin
                for (int k = 0; k < MXCLUSTERS; k++) clusters_out[k*ADRB +: ADRB] <= cl_buf[k];
                cluster_vld <= thermometer(cnt);
                cluster_cnt <= cnt;
                overflow    <= ovf_sticky;
                frame_done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cluster_address_encoder.sv
// tb/tb_cluster_address_encoder.sv - self-checking bench for cluster_address_encoder
module tb_cluster_address_encoder;

    localparam int DEPTH = 2048;

    logic         clock = 1'b0;
    logic         reset;
    logic         frame_start;
    logic [767:0] vpfs_in;
    logic [9:0]   adr_out;
    logic         adr_vld;
    logic [79:0]  clusters_out;
    logic [7:0]   cluster_vld;
    logic [3:0]   cluster_cnt;
    logic         overflow;
    logic         frame_done;

    cluster_address_encoder dut (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .vpfs_in      (vpfs_in),
        .adr_out      (adr_out),
        .adr_vld      (adr_vld),
        .clusters_out (clusters_out),
        .cluster_vld  (cluster_vld),
        .cluster_cnt  (cluster_cnt),
        .overflow     (overflow),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_idx = 0;

    bit           st_rst [DEPTH];
    bit           st_fs  [DEPTH];
    logic [767:0] st_vec [DEPTH];

    logic [9:0]  obs_adr [DEPTH];
    logic        obs_vld [DEPTH];
    logic [79:0] obs_cl  [DEPTH];
    logic [7:0]  obs_cv  [DEPTH];
    logic [3:0]  obs_cc  [DEPTH];
    logic        obs_ovf [DEPTH];
    logic        obs_fd  [DEPTH];

    always @(posedge clock) cyc <= cyc + 1;

    // Record outputs away from the active edge, indexed by cycle number
    always @(negedge clock) begin
        if (cyc < DEPTH) begin
            obs_adr[cyc] <= adr_out;
            obs_vld[cyc] <= adr_vld;
            obs_cl[cyc]  <= clusters_out;
            obs_cv[cyc]  <= cluster_vld;
            obs_cc[cyc]  <= cluster_cnt;
            obs_ovf[cyc] <= overflow;
            obs_fd[cyc]  <= frame_done;
        end
    end

    task automatic drive(input bit r, input bit fs, input logic [767:0] v);
        @(negedge clock);
        reset       = r;
        frame_start = fs;
        vpfs_in     = v;
        last_idx    = cyc;
        if (cyc < DEPTH) begin
            st_rst[cyc] = r;
            st_fs[cyc]  = fs;
            st_vec[cyc] = v;
        end else begin
            $display("FAIL cycle_budget got %0d limit %0d", cyc, DEPTH);
            $fatal(1, "cycle budget exceeded");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    function automatic logic [767:0] onehot(input int i);
        logic [767:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [767:0] rand_vec();
        logic [767:0] v;
        v = '0;
        repeat ($urandom_range(0, 11)) begin
            case ($urandom_range(0, 5))
                0:       v[0]   = 1'b1;
                1:       v[63]  = 1'b1;
                2:       v[64]  = 1'b1;
                3:       v[767] = 1'b1;
                default: v[$urandom_range(0, 767)] = 1'b1;
            endcase
        end
        return v;
    endfunction

    function automatic int lsb_of(input logic [767:0] v);
        for (int i = 0; i < 768; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        int r0;
        logic [767:0] v;
        v = '1;
        drive(1'b1, 1'b1, v);
        r0 = last_idx;
        drive(1'b1, 1'b1, v);
        drive(1'b1, 1'b0, v);
        idle(4);
        n_checks++; if (obs_adr[r0+2] !== 10'd0) $display("FAIL reset_adr_out got %0d want 0", obs_adr[r0+2]); else n_pass++;
        n_checks++; if (obs_vld[r0+2] !== 1'b0) $display("FAIL reset_adr_vld got %b want 0", obs_vld[r0+2]); else n_pass++;
        n_checks++; if (obs_cl[r0+2] !== 80'd0) $display("FAIL reset_clusters_out got %h want 0", obs_cl[r0+2]); else n_pass++;
        n_checks++; if (obs_cv[r0+2] !== 8'd0) $display("FAIL reset_cluster_vld got %h want 0", obs_cv[r0+2]); else n_pass++;
        n_checks++; if (obs_cc[r0+2] !== 4'd0) $display("FAIL reset_cluster_cnt got %0d want 0", obs_cc[r0+2]); else n_pass++;
        n_checks++; if (obs_ovf[r0+2] !== 1'b0) $display("FAIL reset_overflow got %b want 0", obs_ovf[r0+2]); else n_pass++;
        n_checks++; if (obs_fd[r0+2] !== 1'b0) $display("FAIL reset_frame_done got %b want 0", obs_fd[r0+2]); else n_pass++;
    endtask

    task automatic test_single_hit();
        int q, p;
        drive(1'b0, 1'b1, '0);
        q = last_idx;
        drive(1'b0, 1'b1, onehot(0));
        idle(4);
        drive(1'b0, 1'b1, '0);
        p = last_idx;
        idle(6);
        n_checks++; if (obs_fd[q+3] !== 1'b0) $display("FAIL single_first_fs_no_publish got %b want 0", obs_fd[q+3]); else n_pass++;
        n_checks++; if (obs_fd[p+3] !== 1'b1) $display("FAIL single_frame_done got %b want 1", obs_fd[p+3]); else n_pass++;
        n_checks++; if (obs_cv[p+3] !== 8'h01) $display("FAIL single_cluster_vld got %h want 01", obs_cv[p+3]); else n_pass++;
        n_checks++; if (obs_cl[p+3][9:0] !== 10'd0) $display("FAIL single_slot0 got %0d want 0", obs_cl[p+3][9:0]); else n_pass++;
        n_checks++; if (obs_cc[p+3] !== 4'd1) $display("FAIL single_cluster_cnt got %0d want 1", obs_cc[p+3]); else n_pass++;
        n_checks++; if (obs_ovf[p+3] !== 1'b0) $display("FAIL single_overflow got %b want 0", obs_ovf[p+3]); else n_pass++;
        n_checks++; if ({obs_fd[p+2], obs_fd[p+4]} !== 2'b00) $display("FAIL single_done_width got %b%b want 00", obs_fd[p+2], obs_fd[p+4]); else n_pass++;
        n_checks++; if (obs_cc[p+5] !== 4'd1) $display("FAIL single_hold_cnt got %0d want 1", obs_cc[p+5]); else n_pass++;
    endtask

    task automatic test_truncation();
        int t, u;
        logic [767:0] v;
        v = onehot(5) | onehot(70) | onehot(700);
        drive(1'b0, 1'b1, v);
        t = last_idx;
        repeat (3) begin
            v = v & (v - 1);
            drive(1'b0, 1'b0, v);
        end
        idle(1);
        drive(1'b0, 1'b1, '0);
        u = last_idx;
        idle(6);
        n_checks++; if ({obs_vld[t+2], obs_adr[t+2]} !== {1'b1, 10'd5}) $display("FAIL trunc_adr0 got %b/%0d want 1/5", obs_vld[t+2], obs_adr[t+2]); else n_pass++;
        n_checks++; if ({obs_vld[t+3], obs_adr[t+3]} !== {1'b1, 10'd70}) $display("FAIL trunc_adr1 got %b/%0d want 1/70", obs_vld[t+3], obs_adr[t+3]); else n_pass++;
        n_checks++; if ({obs_vld[t+4], obs_adr[t+4]} !== {1'b1, 10'd700}) $display("FAIL trunc_adr2 got %b/%0d want 1/700", obs_vld[t+4], obs_adr[t+4]); else n_pass++;
        n_checks++; if ({obs_vld[t+5], obs_adr[t+5]} !== {1'b0, 10'd0}) $display("FAIL trunc_empty got %b/%0d want 0/0", obs_vld[t+5], obs_adr[t+5]); else n_pass++;
        n_checks++; if (obs_cl[u+3][29:0] !== {10'd700, 10'd70, 10'd5}) $display("FAIL trunc_slots got %h want slots 5,70,700", obs_cl[u+3][29:0]); else n_pass++;
        n_checks++; if (obs_cv[u+3] !== 8'h07) $display("FAIL trunc_cluster_vld got %h want 07", obs_cv[u+3]); else n_pass++;
        n_checks++; if (obs_cc[u+3] !== 4'd3) $display("FAIL trunc_cluster_cnt got %0d want 3", obs_cc[u+3]); else n_pass++;
    endtask

    task automatic test_overflow();
        int t, u;
        logic [767:0] v;
        v = '0;
        for (int k = 0; k < 10; k++) v[k*64] = 1'b1;
        drive(1'b0, 1'b1, v);
        t = last_idx;
        repeat (9) begin
            v = v & (v - 1);
            drive(1'b0, 1'b0, v);
        end
        idle(3);
        drive(1'b0, 1'b1, '0);
        u = last_idx;
        idle(6);
        n_checks++; if (obs_fd[u+3] !== 1'b1) $display("FAIL ovf_frame_done got %b want 1", obs_fd[u+3]); else n_pass++;
        n_checks++; if (obs_cc[u+3] !== 4'd8) $display("FAIL ovf_cluster_cnt got %0d want 8", obs_cc[u+3]); else n_pass++;
        n_checks++; if (obs_cv[u+3] !== 8'hFF) $display("FAIL ovf_cluster_vld got %h want FF", obs_cv[u+3]); else n_pass++;
        n_checks++; if (obs_ovf[u+3] !== 1'b1) $display("FAIL ovf_overflow got %b want 1", obs_ovf[u+3]); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (int'(obs_cl[u+3][k*10 +: 10]) !== k * 64)
                $display("FAIL ovf_slot%0d got %0d want %0d", k, obs_cl[u+3][k*10 +: 10], k * 64);
            else n_pass++;
        end
        n_checks++; if ({obs_vld[t+11], obs_adr[t+11]} !== {1'b1, 10'd576}) $display("FAIL ovf_last_adr got %b/%0d want 1/576", obs_vld[t+11], obs_adr[t+11]); else n_pass++;
    endtask

    task automatic test_empty();
        int t, u;
        drive(1'b0, 1'b1, '0);
        t = last_idx;
        idle(5);
        drive(1'b0, 1'b1, '0);
        u = last_idx;
        idle(6);
        for (int k = t + 2; k <= u + 2; k++) begin
            n_checks++;
            if (obs_vld[k] !== 1'b0) $display("FAIL empty_adr_vld cyc %0d got %b want 0", k, obs_vld[k]); else n_pass++;
        end
        n_checks++; if (obs_fd[u+3] !== 1'b1) $display("FAIL empty_frame_done got %b want 1", obs_fd[u+3]); else n_pass++;
        n_checks++; if (obs_cv[u+3] !== 8'h00) $display("FAIL empty_cluster_vld got %h want 00", obs_cv[u+3]); else n_pass++;
        n_checks++; if (obs_cc[u+3] !== 4'd0) $display("FAIL empty_cluster_cnt got %0d want 0", obs_cc[u+3]); else n_pass++;
        n_checks++; if (obs_ovf[u+3] !== 1'b0) $display("FAIL empty_overflow got %b want 0", obs_ovf[u+3]); else n_pass++;
    endtask

    task automatic test_boundary();
        int a, b, c;
        drive(1'b0, 1'b1, onehot(767));
        a = last_idx;
        idle(2);
        drive(1'b0, 1'b1, onehot(767));
        b = last_idx;
        idle(2);
        drive(1'b0, 1'b1, '0);
        c = last_idx;
        idle(6);
        n_checks++; if ({obs_vld[a+2], obs_adr[a+2]} !== {1'b1, 10'd767}) $display("FAIL bnd_adr_a got %b/%0d want 1/767", obs_vld[a+2], obs_adr[a+2]); else n_pass++;
        n_checks++; if ({obs_vld[b+2], obs_adr[b+2]} !== {1'b1, 10'd767}) $display("FAIL bnd_adr_b got %b/%0d want 1/767", obs_vld[b+2], obs_adr[b+2]); else n_pass++;
        n_checks++; if ({obs_fd[b+3], obs_cc[b+3], obs_cl[b+3][9:0]} !== {1'b1, 4'd1, 10'd767}) $display("FAIL bnd_publish_a got fd%b cnt%0d slot0 %0d want fd1 cnt1 slot0 767", obs_fd[b+3], obs_cc[b+3], obs_cl[b+3][9:0]); else n_pass++;
        n_checks++; if ({obs_fd[c+3], obs_cc[c+3], obs_cl[c+3][9:0]} !== {1'b1, 4'd1, 10'd767}) $display("FAIL bnd_publish_b got fd%b cnt%0d slot0 %0d want fd1 cnt1 slot0 767", obs_fd[c+3], obs_cc[c+3], obs_cl[c+3][9:0]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t;
        drive(1'b0, 1'b1, onehot(1));
        t = last_idx;
        drive(1'b0, 1'b1, onehot(2));
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b1, '0);
        idle(6);
        n_checks++; if ({obs_fd[t+4], obs_fd[t+5], obs_fd[t+6]} !== 3'b111) $display("FAIL b2b_done got %b%b%b want 111", obs_fd[t+4], obs_fd[t+5], obs_fd[t+6]); else n_pass++;
        n_checks++; if ({obs_cc[t+4], obs_cl[t+4][9:0]} !== {4'd1, 10'd1}) $display("FAIL b2b_frame0 got cnt%0d slot0 %0d want cnt1 slot0 1", obs_cc[t+4], obs_cl[t+4][9:0]); else n_pass++;
        n_checks++; if ({obs_cc[t+5], obs_cl[t+5][9:0]} !== {4'd1, 10'd2}) $display("FAIL b2b_frame1 got cnt%0d slot0 %0d want cnt1 slot0 2", obs_cc[t+5], obs_cl[t+5][9:0]); else n_pass++;
        n_checks++; if ({obs_cc[t+6], obs_cv[t+6]} !== {4'd0, 8'h00}) $display("FAIL b2b_frame2 got cnt%0d vld %h want cnt0 vld 00", obs_cc[t+6], obs_cv[t+6]); else n_pass++;
        n_checks++; if (obs_fd[t+7] !== 1'b0) $display("FAIL b2b_done_end got %b want 0", obs_fd[t+7]); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int t, r, u1, u2;
        logic [767:0] v;
        v = onehot(10) | onehot(20) | onehot(30);
        drive(1'b0, 1'b1, v);
        t = last_idx;
        repeat (2) begin
            v = v & (v - 1);
            drive(1'b0, 1'b0, v);
        end
        idle(3);
        drive(1'b1, 1'b0, '0);
        r = last_idx;
        idle(2);
        drive(1'b0, 1'b1, onehot(9));
        u1 = last_idx;
        idle(3);
        drive(1'b0, 1'b1, '0);
        u2 = last_idx;
        idle(6);
        n_checks++; if ({obs_vld[t+4], obs_adr[t+4]} !== {1'b1, 10'd30}) $display("FAIL rmf_third_adr got %b/%0d want 1/30", obs_vld[t+4], obs_adr[t+4]); else n_pass++;
        n_checks++; if ({obs_adr[r+1], obs_vld[r+1], obs_fd[r+1], obs_ovf[r+1]} !== 13'd0) $display("FAIL rmf_stream_zero got adr%0d vld%b fd%b ovf%b want all 0", obs_adr[r+1], obs_vld[r+1], obs_fd[r+1], obs_ovf[r+1]); else n_pass++;
        n_checks++; if ({obs_cl[r+1], obs_cv[r+1], obs_cc[r+1]} !== 92'd0) $display("FAIL rmf_publish_zero got cl %h vld %h cnt %0d want all 0", obs_cl[r+1], obs_cv[r+1], obs_cc[r+1]); else n_pass++;
        n_checks++; if (obs_fd[u1+3] !== 1'b0) $display("FAIL rmf_no_publish got %b want 0", obs_fd[u1+3]); else n_pass++;
        n_checks++; if ({obs_fd[u2+3], obs_cc[u2+3], obs_cv[u2+3], obs_cl[u2+3][9:0]} !== {1'b1, 4'd1, 8'h01, 10'd9}) $display("FAIL rmf_publish got fd%b cnt%0d vld %h slot0 %0d want fd1 cnt1 vld 01 slot0 9", obs_fd[u2+3], obs_cc[u2+3], obs_cv[u2+3], obs_cl[u2+3][9:0]); else n_pass++;
    endtask

    // Randomized truncator traffic with occasional resets, checked against a frame-level list model
    task automatic test_random();
        int k0, kend, a;
        bit sv, tag, m_primed, m_fd, m_ovf;
        int m_list[$];
        int m_pub[8];
        int m_cnt;
        logic [7:0] ecv;
        logic [767:0] cur;
        bit r, fs;
        drive(1'b1, 1'b0, '0);
        k0 = last_idx;
        drive(1'b1, 1'b0, '0);
        cur = '0;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            fs = ($urandom_range(0, 5) == 0);
            if (fs) cur = rand_vec();
            else    cur = cur & (cur - 1);
            drive(r, fs, cur);
        end
        idle(8);
        kend = last_idx - 2;

        m_primed = 0; m_fd = 0; m_ovf = 0; m_cnt = 0;
        m_list.delete();
        for (int s = 0; s < 8; s++) m_pub[s] = 0;

        for (int k = k0 + 1; k <= kend; k++) begin
            ecv = 8'((1 << m_cnt) - 1);
            n_checks++; if (obs_fd[k] !== m_fd) $display("FAIL rnd_frame_done cyc %0d got %b want %b", k, obs_fd[k], m_fd); else n_pass++;
            n_checks++; if (obs_cc[k] !== 4'(m_cnt)) $display("FAIL rnd_cluster_cnt cyc %0d got %0d want %0d", k, obs_cc[k], m_cnt); else n_pass++;
            n_checks++; if (obs_cv[k] !== ecv) $display("FAIL rnd_cluster_vld cyc %0d got %h want %h", k, obs_cv[k], ecv); else n_pass++;
            n_checks++; if (obs_ovf[k] !== m_ovf) $display("FAIL rnd_overflow cyc %0d got %b want %b", k, obs_ovf[k], m_ovf); else n_pass++;
            for (int s = 0; s < m_cnt; s++) begin
                n_checks++;
                if (int'(obs_cl[k][s*10 +: 10]) !== m_pub[s])
                    $display("FAIL rnd_slot%0d cyc %0d got %0d want %0d", s, k, obs_cl[k][s*10 +: 10], m_pub[s]);
                else n_pass++;
            end

            sv  = !st_rst[k-2] && !st_rst[k-1];
            a   = sv ? lsb_of(st_vec[k-2]) : -1;
            tag = sv && st_fs[k-2];
            n_checks++;
            if ({obs_vld[k], obs_adr[k]} !== {a >= 0, (a >= 0) ? 10'(a) : 10'd0})
                $display("FAIL rnd_stream cyc %0d got %b/%0d want %b/%0d", k, obs_vld[k], obs_adr[k], a >= 0, (a >= 0) ? a : 0);
            else n_pass++;

            if (st_rst[k]) begin
                m_primed = 0; m_fd = 0; m_ovf = 0; m_cnt = 0;
                m_list.delete();
                for (int s = 0; s < 8; s++) m_pub[s] = 0;
            end else begin
                m_fd = 0;
                if (tag) begin
                    if (m_primed) begin
                        m_cnt = (m_list.size() > 8) ? 8 : m_list.size();
                        for (int s = 0; s < m_cnt; s++) m_pub[s] = m_list[s];
                        m_ovf = (m_list.size() > 8);
                        m_fd  = 1;
                    end
                    m_primed = 1;
                    m_list.delete();
                    if (a >= 0) m_list.push_back(a);
                end else if (a >= 0) begin
                    m_list.push_back(a);
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        vpfs_in     = '0;
        test_reset();
        test_single_hit();
        test_truncation();
        test_overflow();
        test_empty();
        test_boundary();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
